// File: rtl/dlx_mem_ctrl_pkg.sv
// Shared types and constants for the DLX memory access controller.
// Holds the FSM state encoding, default widths and the error fill value.
package dlx_mem_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_DONE   = 2'b10
   } state_t;

   localparam int ADDR_W_DEF  = 32;
   localparam int DATA_W_DEF  = 32;
   localparam int TIMEOUT_DEF = 15;
   localparam int CNT_W       = 8;

   // Replicated across the data width to form the all-ones error word.
   localparam logic ERR_FILL = 1'b1;

endpackage

// File: rtl/dlx_mem_ctrl.sv
// DLX memory access controller: one strobe/ack bus cycle per request.
// Ports: clk/reset (active-low async), REQ/MR/MW/addr/wdata request side,
// busy/rdata/bus_err/err_clr to control, mem_* external bus.
module dlx_mem_ctrl
   import dlx_mem_ctrl_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              REQ,
   input  logic              MR,
   input  logic              MW,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              busy,
   output logic [DATA_W-1:0] rdata,
   output logic              bus_err,
   input  logic              err_clr,
   output logic              mem_as,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_dout,
   input  logic [DATA_W-1:0] mem_din,
   input  logic              mem_ack
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t             state_q;
   state_t             state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic               wr_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [DATA_W-1:0]  dout_q;
   logic [DATA_W-1:0]  rdata_q;
   logic               err_q;

   logic accept;
   logic set_err;
   logic ld_rd;
   logic cnt_inc;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      set_err = 1'b0;
      ld_rd   = 1'b0;
      cnt_inc = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (REQ) begin
               if (MR ^ MW) begin
                  accept  = 1'b1;
                  state_d = ST_ACCESS;
               end else begin
                  set_err = 1'b1;
                  state_d = ST_DONE;
               end
            end
         end
         ST_ACCESS: begin
            // An ack in the last allowed cycle still completes normally.
            if (mem_ack) begin
               ld_rd   = !wr_q;
               state_d = ST_DONE;
            end else if (cnt_q == CNT_LAST) begin
               set_err = 1'b1;
               state_d = ST_DONE;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         dout_q  <= '0;
      end else if (accept) begin
         cnt_q   <= '0;
         wr_q    <= MW;
         addr_q  <= addr;
         dout_q  <= wdata;
      end else if (cnt_inc) begin
         cnt_q   <= cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)       rdata_q <= '0;
      else if (set_err) rdata_q <= {DATA_W{ERR_FILL}};
      else if (ld_rd)   rdata_q <= mem_din;
   end

   // A set event in the same cycle as err_clr keeps the flag raised.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)       err_q <= 1'b0;
      else if (set_err) err_q <= 1'b1;
      else if (err_clr) err_q <= 1'b0;
   end

   assign mem_as   = (state_q == ST_ACCESS);
   assign mem_wr   = mem_as & wr_q;
   assign mem_addr = addr_q;
   assign mem_dout = dout_q;
   assign rdata    = rdata_q;
   assign bus_err  = err_q;
   assign busy     = mem_as | ((state_q == ST_IDLE) & REQ);

endmodule

// File: tb/tb_dlx_mem_ctrl.sv
// Self-checking bench for dlx_mem_ctrl (TIMEOUT=4).
// Table-driven transactions plus directed multi-cycle sequences.
module tb_dlx_mem_ctrl;

   typedef struct {
      string       name;
      logic        mr;
      logic        mw;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] din;
      int          waits;
      int          exp_as;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        REQ = 1'b0;
   logic        MR = 1'b0;
   logic        MW = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic        busy;
   logic [31:0] rdata;
   logic        bus_err;
   logic        err_clr = 1'b0;
   logic        mem_as;
   logic        mem_wr;
   logic [31:0] mem_addr;
   logic [31:0] mem_dout;
   logic [31:0] mem_din = '0;
   logic        mem_ack = 1'b0;

   int n_chk = 0;
   int n_err = 0;

   dlx_mem_ctrl #(
      .ADDR_W (32),
      .DATA_W (32),
      .TIMEOUT(4)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .REQ     (REQ),
      .MR      (MR),
      .MW      (MW),
      .addr    (addr),
      .wdata   (wdata),
      .busy    (busy),
      .rdata   (rdata),
      .bus_err (bus_err),
      .err_clr (err_clr),
      .mem_as  (mem_as),
      .mem_wr  (mem_wr),
      .mem_addr(mem_addr),
      .mem_dout(mem_dout),
      .mem_din (mem_din),
      .mem_ack (mem_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic txn(input vec_t v);
      int  as_cnt;
      bit  done;
      REQ   = 1'b1;
      MR    = v.mr;
      MW    = v.mw;
      addr  = v.addr;
      wdata = v.wdata;
      mem_din = v.din;
      #1;
      chk({v.name, " busy_c0"}, 32'(busy), 32'd1);
      tick();
      as_cnt = 0;
      done   = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         if (mem_as) begin
            if (c == 0) begin
               chk({v.name, " mem_wr"}, 32'(mem_wr), 32'(v.mw));
               chk({v.name, " mem_addr"}, mem_addr, v.addr);
               chk({v.name, " mem_dout"}, mem_dout, v.wdata);
            end
            chk({v.name, " busy_acc"}, 32'(busy), 32'd1);
            as_cnt++;
            mem_ack = (c == v.waits);
            tick();
            mem_ack = 1'b0;
         end else begin
            done = 1'b1;
         end
      end
      chk({v.name, " as_cycles"}, 32'(as_cnt), 32'(v.exp_as));
      chk({v.name, " busy_done"}, 32'(busy), 32'd0);
      chk({v.name, " rdata"}, rdata, v.exp_rdata);
      chk({v.name, " bus_err"}, 32'(bus_err), 32'(v.exp_err));
      REQ = 1'b0;
      MR  = 1'b0;
      MW  = 1'b0;
      tick();
      chk({v.name, " idle_as"}, 32'(mem_as), 32'd0);
      chk({v.name, " idle_busy"}, 32'(busy), 32'd0);
   endtask

   vec_t vecs[6];
   vec_t rst_v;

   initial begin
      vecs[0] = '{"rd0w", 1, 0, 32'h40, 32'h0, 32'hDEADBEEF,
                  0, 1, 32'hDEADBEEF, 0};
      vecs[1] = '{"wr3w", 0, 1, 32'h80, 32'h12345678, 32'h0,
                  3, 4, 32'hDEADBEEF, 0};
      vecs[2] = '{"tmo", 1, 0, 32'h44, 32'h0, 32'h0,
                  99, 4, 32'hFFFFFFFF, 1};
      vecs[3] = '{"sticky", 1, 0, 32'h48, 32'h0, 32'h0BADF00D,
                  1, 2, 32'h0BADF00D, 1};
      vecs[4] = '{"ill11", 1, 1, 32'h4C, 32'h0, 32'h0,
                  0, 0, 32'hFFFFFFFF, 1};
      vecs[5] = '{"ill00", 0, 0, 32'h50, 32'h0, 32'h0,
                  0, 0, 32'hFFFFFFFF, 1};
      rst_v   = '{"post_rst", 1, 0, 32'h204, 32'h0, 32'h13579BDF,
                  2, 3, 32'h13579BDF, 0};

      // Reset state
      REQ = 1'b1;
      #3;
      chk("rst busy_follows_req", 32'(busy), 32'd1);
      REQ = 1'b0;
      #1;
      chk("rst busy_low", 32'(busy), 32'd0);
      chk("rst rdata", rdata, 32'h0);
      chk("rst bus_err", 32'(bus_err), 32'd0);
      chk("rst mem_as", 32'(mem_as), 32'd0);
      chk("rst mem_wr", 32'(mem_wr), 32'd0);
      chk("rst mem_addr", mem_addr, 32'h0);
      chk("rst mem_dout", mem_dout, 32'h0);
      #18;
      reset = 1'b1;
      tick();

      foreach (vecs[i]) txn(vecs[i]);

      // err_clr, then illegal request with simultaneous clear
      chk("addr_hold_after_ill", mem_addr, 32'h48);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("err_clr", 32'(bus_err), 32'd0);
      REQ = 1'b1; MR = 1'b1; MW = 1'b1; err_clr = 1'b1;
      tick();
      chk("set_wins bus_err", 32'(bus_err), 32'd1);
      chk("set_wins mem_as", 32'(mem_as), 32'd0);
      chk("set_wins busy", 32'(busy), 32'd0);
      REQ = 1'b0; MR = 1'b0; MW = 1'b0; err_clr = 1'b0;
      tick();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("err_clr2", 32'(bus_err), 32'd0);

      // Back-to-back store then fetch, REQ held through DONE
      REQ = 1'b1; MW = 1'b1; MR = 1'b0;
      addr = 32'h300; wdata = 32'hCAFEF00D;
      #1;
      chk("b2b busy_c0", 32'(busy), 32'd1);
      tick();
      chk("b2b st_as", 32'(mem_as), 32'd1);
      chk("b2b st_wr", 32'(mem_wr), 32'd1);
      chk("b2b st_dout", mem_dout, 32'hCAFEF00D);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("b2b done_as", 32'(mem_as), 32'd0);
      chk("b2b done_busy", 32'(busy), 32'd0);
      chk("b2b st_rdata", rdata, 32'hFFFFFFFF);
      MW = 1'b0; MR = 1'b1; addr = 32'h304;
      #1;
      chk("b2b done_busy2", 32'(busy), 32'd0);
      tick();
      chk("b2b idle_as", 32'(mem_as), 32'd0);
      chk("b2b idle_busy", 32'(busy), 32'd1);
      tick();
      chk("b2b fe_as", 32'(mem_as), 32'd1);
      chk("b2b fe_wr", 32'(mem_wr), 32'd0);
      chk("b2b fe_addr", mem_addr, 32'h304);
      mem_din = 32'h55AA33CC;
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      REQ = 1'b0; MR = 1'b0;
      chk("b2b fe_rdata", rdata, 32'h55AA33CC);
      chk("b2b fe_busy", 32'(busy), 32'd0);
      chk("b2b bus_err", 32'(bus_err), 32'd0);
      tick();
      chk("b2b end_as", 32'(mem_as), 32'd0);

      // Reset in the 2nd wait cycle of a read
      REQ = 1'b1; MR = 1'b1; addr = 32'h200; wdata = 32'h77;
      tick();
      chk("rma as_w1", 32'(mem_as), 32'd1);
      tick();
      chk("rma as_w2", 32'(mem_as), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("rma mem_as", 32'(mem_as), 32'd0);
      chk("rma mem_wr", 32'(mem_wr), 32'd0);
      chk("rma mem_addr", mem_addr, 32'h0);
      chk("rma mem_dout", mem_dout, 32'h0);
      chk("rma rdata", rdata, 32'h0);
      chk("rma bus_err", 32'(bus_err), 32'd0);
      chk("rma busy_req", 32'(busy), 32'd1);
      REQ = 1'b0; MR = 1'b0;
      #1;
      chk("rma busy_noreq", 32'(busy), 32'd0);
      #2;
      reset = 1'b1;
      tick();
      chk("rma idle_as", 32'(mem_as), 32'd0);
      txn(rst_v);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/dlx_mem_ctrl.md
# dlx_mem_ctrl

Memory access controller between the DLX control FSM and the external word-addressed memory bus. It accepts one access request at a time from the control's request/read/write strobes and runs a strobe/acknowledge bus cycle with a bounded wait. It drives the `busy` input that holds the control in its FETCH, LOAD and STORE states. Read data is returned on a held output for the instruction and MDR registers.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `TIMEOUT`, 15, maximum ACCESS cycles without `mem_ack` before abort (range 1..255)

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset (0 = reset)
- `REQ`  in  1  access request from control
- `MR`  in  1  read request
- `MW`  in  1  write request
- `addr`  in  ADDR_W  access address
- `wdata`  in  DATA_W  store data
- `busy`  out  1  access in progress; control must hold its request
- `rdata`  out  DATA_W  last read data, held
- `bus_err`  out  1  sticky error flag
- `err_clr`  in  1  clears `bus_err`
- `mem_as`  out  1  address strobe
- `mem_wr`  out  1  write qualifier
- `mem_addr`  out  ADDR_W  bus address
- `mem_dout`  out  DATA_W  bus write data
- `mem_din`  in  DATA_W  bus read data
- `mem_ack`  in  1  bus acknowledge

## Operation
- The FSM has three states: IDLE, ACCESS and DONE. State codes come from a shared package.
- **IDLE**
  - If `REQ`=1 and exactly one of `MR`/`MW` is 1: latch `addr`, `wdata` and `MW`, clear the wait counter, and go to ACCESS.
  - If `REQ`=1 and `MR`=`MW` (both 0 or both 1): no bus cycle. Set `bus_err`, load `rdata` with all ones, and go to DONE.
- **ACCESS**
  - Outputs: `mem_as`=1, `mem_wr`=latched MW, `mem_addr`/`mem_dout` = latched values.
  - On `mem_ack`=1: if the access is a read, `rdata` <= `mem_din`. Go to DONE.
  - Otherwise the counter increments. When the counter equals TIMEOUT-1 with no ack: set `bus_err`, `rdata` <= all ones, go to DONE.
- **DONE**
  - `busy`=0 for exactly one cycle, then go to IDLE unconditionally.
  - `REQ` still high in DONE must not start a new access.
- **busy** is combinational: 1 in ACCESS, and 1 in IDLE when `REQ`=1. It is 0 otherwise, including all of DONE.
- **bus_err**
  - Sticky; cleared only by `err_clr`=1 or reset.
  - If `err_clr` and a set event occur in the same cycle, the set wins.
- **Output hold**
  - `rdata` holds its value until the next completed read or error.
  - Writes never modify `rdata`.
- **Reset values:**
  - Every output is 0 during and after reset: state IDLE, `rdata`, `bus_err`, `mem_as`, `mem_wr`, `mem_addr`, `mem_dout`.
  - `busy` follows `REQ` combinationally even while `reset`=0.
  - Reset asserted during ACCESS drops `mem_as` immediately (asynchronous). No completion occurs.
- **Wait counter** is 8 bits and never wraps; reaching TIMEOUT-1 always exits ACCESS.
- `mem_addr`/`mem_dout` are registered and change only on accept in IDLE.

## Timing
- Cycle 0: IDLE, `REQ`=1, `busy`=1.
- Cycle 1: ACCESS, `mem_as`=1.
- Zero-wait memory (`mem_ack` in cycle 1): DONE in cycle 2 with `busy`=0 and `rdata` valid.
  - The control samples `busy`=0 at the end of cycle 2.
  - Minimum busy span is 2 cycles.
- N wait cycles: ack in cycle 1+N, DONE in cycle 2+N.
- Timeout: `mem_as` is high for exactly TIMEOUT cycles; DONE follows in cycle TIMEOUT+1.
- Back-to-back accesses: a new `REQ` in the first IDLE cycle after DONE is accepted with no bubble beyond DONE.
- `rdata` is valid from DONE onward and is stable while the control's IR/MDR enable is active.

## Structure
- Shared package holds:
  - the state encoding (IDLE=2'b00, ACCESS=2'b01, DONE=2'b10)
  - the all-ones error data constant
  - default width constants
- Single module, no sub-module.
- The wait counter is inline; it is too small to split out.

## Test plan
- **Zero-wait read:** `REQ`=1, `MR`=1, `addr`=0x40, `mem_ack` in first ACCESS cycle with `mem_din`=0xDEADBEEF. Expect `busy` high 2 cycles, `rdata`=0xDEADBEEF in DONE, `mem_wr`=0.
- **Write with 3 wait states:** `MW`=1, `wdata`=0x12345678. Expect `mem_as` high 4 cycles, `mem_wr`=1, `mem_dout`=0x12345678, `rdata` unchanged, `busy` low in cycle 5.
- **Timeout, TIMEOUT=4, no ack:** expect `mem_as` high exactly 4 cycles, `bus_err`=1, `rdata`=0xFFFFFFFF, DONE next.
- **Illegal request** (`REQ`=1 with `MR`=`MW`=1): expect no `mem_as`, `bus_err`=1, `busy` 0 one cycle later. Then `err_clr` clears the flag. Also check simultaneous set and clear leaves `bus_err`=1.
- **Back-to-back:** a store followed immediately by a fetch request. Expect a single DONE cycle between the two ACCESS phases, with `REQ` held in DONE not restarting.
- **Reset mid-ACCESS:** deassert `reset` during the 2nd wait cycle. Expect `mem_as`=0 asynchronously, all outputs 0, and a clean restart on the next `REQ`.
